// File: rtl/rv32i_pkg.sv
// Shared constants and FSM state type for the RV32I register file slice.
package rv32i_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    READ_VALID = 2'd2
  } regfile_state_e;

endpackage

// File: rtl/rv32i_regfile_array.sv
// Register storage x1..x31: one write port, one combinational read port,
// synchronous clear that beats a same-edge write, x0 hard-wired to zero.
module rv32i_regfile_array
  import rv32i_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [WORD_SIZE-1:0]  i_wdata,
  input  logic [REG_ADDR_W-1:0] i_raddr,
  output logic [WORD_SIZE-1:0]  o_rdata
);

  logic [WORD_SIZE-1:0] regs_q [1:NUM_REGS-1];
  logic [WORD_SIZE-1:0] regs_d [1:NUM_REGS-1];

  always_comb begin
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
      if (i_clear) begin
        regs_d[i] = '0;
      end else if (i_we && (i_waddr == REG_ADDR_W'(i))) begin
        regs_d[i] = i_wdata;
      end
    end
  end

  // No entry matches address 0, so x0 reads as zero and writes to it vanish.
  always_comb begin
    o_rdata = '0;
    for (int unsigned i = 1; i < NUM_REGS; i++) begin
      if (i_raddr == REG_ADDR_W'(i)) begin
        o_rdata = regs_q[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

endmodule

// File: rtl/rv32i_register_file.sv
// RV32I register file with a fixed-latency read FSM (READ_LATENCY 1..4).
// Optional same-edge write forwarding: define REGFILE_WRITE_BYPASS_EN.
module rv32i_register_file
  import rv32i_pkg::*;
#(
  parameter int unsigned WORD_SIZE    = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_register_rst,
  input  logic                  i_register_read_en,
  input  logic [REG_ADDR_W-1:0] i_register_addr,
  output logic                  o_register_read_valid,
  output logic [WORD_SIZE-1:0]  o_register_read_data,
  input  logic                  i_writeback_en,
  input  logic [REG_ADDR_W-1:0] i_writeback_addr,
  input  logic [WORD_SIZE-1:0]  i_writeback_data,
  output logic                  o_busy
);

  localparam int unsigned        CNT_W    = 2;
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  regfile_state_e         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0]  addr_q, addr_d;
  logic                   valid_q, valid_d;
  logic [WORD_SIZE-1:0]   data_q, data_d;
  logic [WORD_SIZE-1:0]   arr_rdata;
  logic [WORD_SIZE-1:0]   capture_data;

  rv32i_regfile_array #(
    .WORD_SIZE (WORD_SIZE)
  ) u_array (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clear (i_register_rst),
    .i_we    (i_writeback_en),
    .i_waddr (i_writeback_addr),
    .i_wdata (i_writeback_data),
    .i_raddr (addr_q),
    .o_rdata (arr_rdata)
  );

`ifdef REGFILE_WRITE_BYPASS_EN
  always_comb begin
    capture_data = arr_rdata;
    if (i_writeback_en && (i_writeback_addr == addr_q) && (addr_q != '0)) begin
      capture_data = i_writeback_data;
    end
  end
`else
  always_comb begin
    capture_data = arr_rdata;
  end
`endif

  // Data is captured on the edge leaving READ_VALID, so busy spans READ_LATENCY
  // cycles and the valid pulse lands in the IDLE cycle that follows.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    data_d  = data_q;
    if (i_register_rst) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_register_read_en) begin
            addr_d = i_register_addr;
            if (READ_LATENCY == 1) begin
              state_d = READ_VALID;
              cnt_d   = '0;
            end else begin
              state_d = READ_WAIT;
              cnt_d   = CNT_LOAD;
            end
          end
        end
        READ_WAIT: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = READ_VALID;
          end
        end
        READ_VALID: begin
          valid_d = 1'b1;
          data_d  = capture_data;
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_register_read_valid = valid_q;
  assign o_register_read_data  = data_q;
  assign o_busy                = (state_q != IDLE);

endmodule

// File: doc/rv32i_register_file.md
RV32I_REGISTER_FILE -- requirements
Module: rv32i_register_file

Interface
REQ-001 The module SHALL have parameter WORD_SIZE, default 32, register data width.
REQ-002 The module SHALL have parameter READ_LATENCY, default 1, legal range 1..4; it sets the cycles from request acceptance to data return.
REQ-003 The module SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port i_register_rst, input, 1 bit: synchronous clear of all registers, driven by the decode stage.
REQ-006 The module SHALL have port i_register_read_en, input, 1 bit: read request.
REQ-007 The module SHALL have port i_register_addr, input, 5 bits: read address.
REQ-008 The module SHALL have port o_register_read_valid, output, 1 bit: read data valid, a one-cycle pulse.
REQ-009 The module SHALL have port o_register_read_data, output, WORD_SIZE bits: read data.
REQ-010 The module SHALL have port i_writeback_en, input, 1 bit: write strobe from writeback.
REQ-011 The module SHALL have port i_writeback_addr, input, 5 bits: write address.
REQ-012 The module SHALL have port i_writeback_data, input, WORD_SIZE bits: write data.
REQ-013 The module SHALL have port o_busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, READ_WAIT and READ_VALID.
REQ-015 In IDLE, a high i_register_read_en at an edge SHALL accept the request and capture i_register_addr.
REQ-016 After acceptance, the FSM SHALL enter READ_WAIT and load a down-counter with READ_LATENCY-1.
REQ-017 For READ_LATENCY=1 the FSM SHALL go directly to READ_VALID.
REQ-018 The FSM SHALL leave READ_WAIT for READ_VALID when the counter reaches 0.
REQ-019 o_register_read_valid SHALL be high for exactly one cycle, the cycle after edge N+READ_LATENCY, where N is the acceptance edge.
REQ-020 o_register_read_data SHALL be registered at edge N+READ_LATENCY and held until the next return.
REQ-021 READ_VALID SHALL always return to IDLE; the edge leaving READ_VALID SHALL NOT accept a request.
REQ-022 A request still held high in the next IDLE cycle SHALL be accepted as new, using the address present at that time (supports back-to-back rs1 then rs2 reads).
REQ-023 Changes to i_register_addr after acceptance SHALL be ignored.
REQ-024 A read of x0 SHALL return 0.
REQ-025 A write to x0 SHALL be discarded.
REQ-026 A write with i_writeback_en high SHALL update the register at that edge; writes are accepted in every state.
REQ-027 A write and a read-data capture to the same address at the same edge SHALL return the value defined in Configuration.
REQ-028 i_register_rst SHALL clear all 31 registers at that edge.
REQ-029 i_register_rst SHALL abort any pending read: FSM goes to IDLE and no valid pulse is issued.
REQ-030 When i_register_rst and a write occur at the same edge, the clear SHALL win.

Reset
REQ-031 i_rst_n low SHALL asynchronously force: FSM to IDLE, counter to 0, o_register_read_valid=0, o_register_read_data=0, o_busy=0, all registers to 0.
REQ-032 Reset asserted mid-read SHALL cancel the read with no valid pulse afterwards.

Configuration
REQ-033 With macro REGFILE_WRITE_BYPASS_EN defined, a same-edge write to the captured address (not x0) SHALL be forwarded, so the returned data is i_writeback_data.
REQ-034 Without REGFILE_WRITE_BYPASS_EN, the same-edge case SHALL return the pre-write value; no forwarding logic SHALL be present.

Structure
REQ-035 Package rv32i_pkg SHALL hold REG_ADDR_W=5, NUM_REGS=32 and the regfile_state_e enum (IDLE, READ_WAIT, READ_VALID).
REQ-036 Storage SHALL be a sub-module, rv32i_regfile_array (31x WORD_SIZE flops, one write port, one combinational read port, x0 tied to 0, synchronous clear).
REQ-037 The FSM, counter and bypass logic SHALL reside in rv32i_register_file.

Verification
REQ-038 Bench SHALL check: write x5=0xDEADBEEF, then read x5 with LAT=1 -> valid one cycle after acceptance, data 0xDEADBEEF, o_busy high exactly 1 cycle.
REQ-039 Bench SHALL check: write x0=0x12345678, then read x0 -> data 0x00000000.
REQ-040 Bench SHALL check: LAT=3, read_en held high, addr x1 then x2 (x1=0x11, x2=0x22) -> valid pulses at N+3 and N+7, data 0x11 then 0x22.
REQ-041 Bench SHALL check: write x7=0xA5A5A5A5 on the capture edge of a x7 read (old value 0x1) -> 0xA5A5A5A5 with REGFILE_WRITE_BYPASS_EN, 0x00000001 without.
REQ-042 Bench SHALL check: i_register_rst pulse during READ_WAIT with a same-edge write x3=0xFF -> no valid pulse, FSM IDLE, later read x3 returns 0.
REQ-043 Bench SHALL check: i_rst_n low mid-read, released -> no valid pulse, all outputs 0, all registers read 0.
